m_vmon: RTL and testbench
=========================

Name: m_vmon

Overview:
Supply-rail supervisor feeding the power-off stage's ov and uv_n inputs. It takes a digitized rail voltage from the ADC sampler, qualifies it against over- and under-voltage thresholds with hysteresis and a consecutive-sample filter, and blanks the first cycles after enable. Its outputs are registered, glitch-free fault flags. The polarity is chosen so that reset and disable both hold the downstream shutdown path asserted (uv_n=0).

Parameters:
W, 10, ADC code width in bits
OV_SET, 900, code at or above which a sample counts as over-voltage
OV_CLR, 860, code at or below which a sample counts as over-voltage-cleared
UV_SET, 600, code at or below which a sample counts as under-voltage
UV_CLR, 640, code at or above which a sample counts as under-voltage-cleared
FILT, 4, number of consecutive qualifying samples needed to change a flag (>=1)
BLANK, 16, clock cycles ignored after enable rises (>=1)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
en  input  1  monitor enable; level sensitive
adc_valid  input  1  one-cycle strobe; adc_code is valid this cycle
adc_code  input  W  unsigned rail sample
ov  output  1  over-voltage flag, active-high
uv_n  output  1  under-voltage flag, active-low (1 = rail above UV)
pgood  output  1  uv_n & ~ov, registered

Behaviour:
- Legal parameters: UV_SET < UV_CLR <= OV_CLR < OV_SET < 2^W. Violations are a fatal elaboration check.
- Reset (async, rst_n=0):
  - state=OFF; ov=0; uv_n=0; pgood=0.
  - Blank counter and both filter counters cleared.
- FSM states: OFF, BLANK, RUN.
  - OFF: flags held at reset values, counters cleared. en=1 -> BLANK.
  - BLANK: blank counter counts clock cycles. adc_valid is ignored. After BLANK cycles -> RUN. en=0 -> OFF.
  - RUN: samples are evaluated. en=0 -> OFF, and ov=0, uv_n=0, pgood=0 the following cycle.
- en dropping in any state goes to OFF on the next edge. This takes priority over a sample arriving in the same cycle.
- Sample evaluation in RUN happens only on adc_valid=1. Cycles with adc_valid=0 leave all counters unchanged.
- OV path:
  - If ov=0: a sample >= OV_SET increments ov_cnt; any other sample clears ov_cnt.
  - If ov=1: a sample <= OV_CLR increments ov_cnt; any other sample clears ov_cnt.
  - When ov_cnt reaches FILT, ov toggles on that same clock edge (flag is registered, visible the cycle after the FILT-th qualifying strobe), and ov_cnt clears.
- UV path, symmetric:
  - If uv_n=0: a sample >= UV_CLR counts toward uv_n=1.
  - If uv_n=1: a sample <= UV_SET counts toward uv_n=0.
  - Non-qualifying samples clear uv_cnt.
- Samples inside a hysteresis band clear the relevant counter and leave the flag unchanged.
- Counters are ceil(log2(FILT+1)) bits wide and never wrap, because they clear on reaching FILT.
- One sample may advance both counters in the same cycle (e.g. uv_n=0 and code >= OV_SET). Both flags update independently in that cycle.
- pgood is registered from the next-state values of uv_n and ov. It rises on the same edge that uv_n rises, provided ov stays 0.
- Reset asserted mid-operation clears everything immediately. No sample is retained.
- Glitch-free requirement: ov, uv_n and pgood come straight from flops, with no combinational path from the inputs.

Test Plan:
- Reset then en=1, adc_valid every 4th cycle with code=750: samples during the first 16 cycles are ignored; uv_n=1 and pgood=1 one cycle after the 4th post-blank strobe; ov stays 0.
- In RUN with uv_n=1, send codes 905,910,850,905,905,905,905 -> ov stays 0 through the 850 sample (counter cleared); ov=1 and pgood=0 one cycle after the 7th strobe.
- With ov=1, send 880 x6 then 860 x4 -> ov stays 1 through the in-band 880 samples; ov=0 and pgood=1 after the 4th 860 sample.
- With uv_n=1, send 600,600,620,600,600,600,600 -> uv_n stays 1 until the 4th consecutive <=600 sample, then uv_n=0 and pgood=0; then 640 x4 -> uv_n=1.
- Drop en for 1 cycle while in RUN with pgood=1 -> next cycle ov=0, uv_n=0, pgood=0; re-enable repeats the 16-cycle blank before any sample counts.
- Pulse rst_n low mid-filter (ov_cnt=3, code=950) -> all outputs 0 immediately; after release and en, 3 more 950 samples do not set ov (needs 4 fresh samples).

Source files
------------

// File: rtl/m_vmon.sv
// m_vmon: supply-rail supervisor.
// Qualifies digitized rail samples against over/under-voltage thresholds
// with hysteresis and a consecutive-sample filter, blanks the first cycles
// after enable, and drives registered fault flags. Reset and disable both
// hold uv_n low so the downstream shutdown path stays asserted.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_OFF  | monitor disabled; flags at safe values, counters cleared
// ST_BLANK| settling window after enable; samples ignored
// ST_RUN  | samples evaluated on adc_valid, flags may change
module m_vmon #(
  parameter int W      = 10,
  parameter int OV_SET = 900,
  parameter int OV_CLR = 860,
  parameter int UV_SET = 600,
  parameter int UV_CLR = 640,
  parameter int FILT   = 4,
  parameter int BLANK  = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         adc_valid,
  input  logic [W-1:0] adc_code,
  output logic         ov,
  output logic         uv_n,
  output logic         pgood
);

  // Threshold ordering and filter/blank lengths are checked at elaboration.
  if (!((UV_SET < UV_CLR) && (UV_CLR <= OV_CLR) && (OV_CLR < OV_SET) &&
        (OV_SET < (1 << W)) && (FILT >= 1) && (BLANK >= 1))) begin : g_bad_params
    $fatal(1, "m_vmon: illegal threshold/filter/blank parameters");
  end

  localparam int CW = $clog2(FILT + 1);
  localparam int BW = (BLANK > 1) ? $clog2(BLANK) : 1;

  localparam logic [W-1:0]  OV_SET_C = W'(OV_SET);
  localparam logic [W-1:0]  OV_CLR_C = W'(OV_CLR);
  localparam logic [W-1:0]  UV_SET_C = W'(UV_SET);
  localparam logic [W-1:0]  UV_CLR_C = W'(UV_CLR);
  localparam logic [CW-1:0] FILT_C   = CW'(FILT);
  localparam logic [BW-1:0] BLANK_LD = BW'(BLANK - 1);

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_BLANK = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t        state;
  logic [BW-1:0] blank_cnt;
  logic [CW-1:0] ov_cnt;
  logic [CW-1:0] uv_cnt;

  logic          ov_hit;
  logic          uv_hit;
  logic [CW-1:0] ov_cnt_inc;
  logic [CW-1:0] uv_cnt_inc;
  logic          ov_nxt;
  logic          uv_n_nxt;
  logic [CW-1:0] ov_cnt_nxt;
  logic [CW-1:0] uv_cnt_nxt;

  // Next flag/counter values: only a strobe in RUN with en held can move
  // them; everywhere else they collapse to the safe (shutdown) values.
  always_comb begin
    ov_hit     = ov   ? (adc_code <= OV_CLR_C) : (adc_code >= OV_SET_C);
    uv_hit     = uv_n ? (adc_code <= UV_SET_C) : (adc_code >= UV_CLR_C);
    ov_cnt_inc = ov_cnt + 1'b1;
    uv_cnt_inc = uv_cnt + 1'b1;
    ov_nxt     = ov;
    uv_n_nxt   = uv_n;
    ov_cnt_nxt = ov_cnt;
    uv_cnt_nxt = uv_cnt;

    if (!en || state != ST_RUN) begin
      ov_nxt     = 1'b0;
      uv_n_nxt   = 1'b0;
      ov_cnt_nxt = '0;
      uv_cnt_nxt = '0;
    end else if (adc_valid) begin
      if (!ov_hit) begin
        ov_cnt_nxt = '0;
      end else if (ov_cnt_inc == FILT_C) begin
        ov_nxt     = ~ov;
        ov_cnt_nxt = '0;
      end else begin
        ov_cnt_nxt = ov_cnt_inc;
      end

      if (!uv_hit) begin
        uv_cnt_nxt = '0;
      end else if (uv_cnt_inc == FILT_C) begin
        uv_n_nxt   = ~uv_n;
        uv_cnt_nxt = '0;
      end else begin
        uv_cnt_nxt = uv_cnt_inc;
      end
    end
  end

  // Sequencer, blank timer and registered outputs; pgood follows the
  // next-state flags so it moves on the same edge as uv_n/ov.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_OFF;
      blank_cnt <= '0;
      ov_cnt    <= '0;
      uv_cnt    <= '0;
      ov        <= 1'b0;
      uv_n      <= 1'b0;
      pgood     <= 1'b0;
    end else begin
      ov_cnt <= ov_cnt_nxt;
      uv_cnt <= uv_cnt_nxt;
      ov     <= ov_nxt;
      uv_n   <= uv_n_nxt;
      pgood  <= uv_n_nxt & ~ov_nxt;

      if (!en) begin
        state     <= ST_OFF;
        blank_cnt <= '0;
      end else begin
        case (state)
          ST_OFF: begin
            state     <= ST_BLANK;
            blank_cnt <= BLANK_LD;
          end
          ST_BLANK: begin
            if (blank_cnt == '0) begin
              state <= ST_RUN;
            end else begin
              blank_cnt <= blank_cnt - 1'b1;
            end
          end
          ST_RUN: begin
            state <= ST_RUN;
          end
          default: begin
            state     <= ST_OFF;
            blank_cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_m_vmon.sv
// Directed bench for m_vmon with default parameters.
// Outputs are checked as the triple {ov, uv_n, pgood}, 1 ns after each
// rising edge; inputs change at the same point.
module tb_m_vmon;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       adc_valid;
  logic [9:0] adc_code;
  logic       ov;
  logic       uv_n;
  logic       pgood;

  int n_cmp = 0;
  int n_bad = 0;

  m_vmon dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .adc_valid (adc_valid),
    .adc_code  (adc_code),
    .ov        (ov),
    .uv_n      (uv_n),
    .pgood     (pgood)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One back-to-back strobe of the given code.
  task automatic strobe(input logic [9:0] code);
    adc_valid = 1'b1;
    adc_code  = code;
    tick();
    adc_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en = 1'b0;
    adc_valid = 1'b0;
    adc_code = '0;
    tick();
    tick();
    n_cmp++;
    if ({ov, uv_n, pgood} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset: got %b want 000", {ov, uv_n, pgood});
    end
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if ({ov, uv_n, pgood} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_off: got %b want 000", {ov, uv_n, pgood});
    end
  endtask

  // en rises in cycle 0; cycles 1..16 are blanking, RUN from cycle 17.
  // Strobes at 2,6,10,14 are blanked; 18,22,26,30 count.
  task automatic test_startup();
    logic [2:0] exp;
    en = 1'b1;
    for (int c = 0; c <= 30; c++) begin
      adc_valid = ((c % 4) == 2);
      adc_code  = 10'd750;
      tick();
      exp = (c >= 30) ? 3'b011 : 3'b000;
      n_cmp++;
      if ({ov, uv_n, pgood} !== exp) begin
        n_bad++;
        $display("FAIL startup c=%0d: got %b want %b", c, {ov, uv_n, pgood}, exp);
      end
    end
    adc_valid = 1'b0;
  endtask

  task automatic test_ov_set();
    logic [9:0] codes [7] = '{10'd905, 10'd910, 10'd850, 10'd905, 10'd905, 10'd905, 10'd905};
    logic [2:0] exp;
    for (int i = 0; i < 7; i++) begin
      strobe(codes[i]);
      exp = (i == 6) ? 3'b110 : 3'b011;
      n_cmp++;
      if ({ov, uv_n, pgood} !== exp) begin
        n_bad++;
        $display("FAIL ov_set i=%0d: got %b want %b", i, {ov, uv_n, pgood}, exp);
      end
    end
  endtask

  task automatic test_ov_clr();
    logic [2:0] exp;
    for (int i = 0; i < 10; i++) begin
      strobe((i < 6) ? 10'd880 : 10'd860);
      exp = (i == 9) ? 3'b011 : 3'b110;
      n_cmp++;
      if ({ov, uv_n, pgood} !== exp) begin
        n_bad++;
        $display("FAIL ov_clr i=%0d: got %b want %b", i, {ov, uv_n, pgood}, exp);
      end
    end
  endtask

  task automatic test_uv();
    logic [9:0] codes [11] = '{10'd600, 10'd600, 10'd620, 10'd600, 10'd600, 10'd600,
                               10'd600, 10'd640, 10'd640, 10'd640, 10'd640};
    logic [2:0] exp;
    for (int i = 0; i < 11; i++) begin
      strobe(codes[i]);
      exp = (i >= 6 && i < 10) ? 3'b000 : 3'b011;
      n_cmp++;
      if ({ov, uv_n, pgood} !== exp) begin
        n_bad++;
        $display("FAIL uv i=%0d: got %b want %b", i, {ov, uv_n, pgood}, exp);
      end
    end
  endtask

  // One-cycle en drop with a coincident strobe, then a fresh blank window
  // with strobes every cycle: RUN from cycle 17, 4th counted strobe at 20.
  task automatic test_en_drop();
    logic [2:0] exp;
    en = 1'b0;
    adc_valid = 1'b1;
    adc_code = 10'd750;
    tick();
    n_cmp++;
    if ({ov, uv_n, pgood} !== 3'b000) begin
      n_bad++;
      $display("FAIL en_drop: got %b want 000", {ov, uv_n, pgood});
    end
    en = 1'b1;
    for (int c = 0; c <= 20; c++) begin
      adc_valid = 1'b1;
      adc_code  = 10'd750;
      tick();
      exp = (c >= 20) ? 3'b011 : 3'b000;
      n_cmp++;
      if ({ov, uv_n, pgood} !== exp) begin
        n_bad++;
        $display("FAIL reblank c=%0d: got %b want %b", c, {ov, uv_n, pgood}, exp);
      end
    end
    adc_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      strobe(10'd950);
      n_cmp++;
      if ({ov, uv_n, pgood} !== 3'b011) begin
        n_bad++;
        $display("FAIL pre_rst i=%0d: got %b want 011", i, {ov, uv_n, pgood});
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({ov, uv_n, pgood} !== 3'b000) begin
      n_bad++;
      $display("FAIL async_rst: got %b want 000", {ov, uv_n, pgood});
    end
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) tick();
    for (int i = 0; i < 4; i++) strobe(10'd750);
    n_cmp++;
    if ({ov, uv_n, pgood} !== 3'b011) begin
      n_bad++;
      $display("FAIL post_rst_uv: got %b want 011", {ov, uv_n, pgood});
    end
    for (int i = 0; i < 4; i++) begin
      strobe(10'd950);
      n_cmp++;
      if ({ov, uv_n, pgood} !== ((i == 3) ? 3'b110 : 3'b011)) begin
        n_bad++;
        $display("FAIL post_rst_ov i=%0d: got %b want %b", i, {ov, uv_n, pgood},
                 ((i == 3) ? 3'b110 : 3'b011));
      end
    end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_ov_set();
    test_ov_clr();
    test_uv();
    test_en_drop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
